// File: rtl/load_store_unit.sv
// Memory-access stage: turns a load/store in execute into one req/ack bus transaction,
// handles byte-lane steering and load extension, and stalls the core while the access is open.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] ALUResult,
  input  logic [31:0] RD2,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        AlignErr,
  output logic        BusErr,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Last counter value before giving up; the counter starts at 0 on the first REQ cycle.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;

  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_be;
  logic [31:0] r_read_data;
  logic        r_align_err;
  logic        r_bus_err;
  logic [7:0]  r_cnt;
  logic [1:0]  r_ld_size;
  logic        r_ld_unsigned;
  logic [1:0]  r_off;

  logic        w_access;
  logic        w_legal;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic        w_stall;
  logic        w_launch;
  logic        w_align_fail;
  logic        w_take_ack;
  logic        w_timeout;
  logic [7:0]  w_lane_byte;
  logic [15:0] w_lane_half;
  logic [31:0] w_load_ext;

  // ---------------------------------------------------------------------------
  // Request decode: legality, alignment and store lane steering
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_access   = MemRead | MemWrite;
    w_legal    = 1'b0;
    w_misalign = 1'b0;
    w_be       = 4'b1111;
    w_wdata    = RD2;

    case (funct3)
      3'b000, 3'b001, 3'b010: w_legal = 1'b1;
      3'b100, 3'b101:         w_legal = ~MemWrite;  // unsigned forms exist for loads only
      default:                w_legal = 1'b0;
    endcase

    case (funct3[1:0])
      2'b01:   w_misalign = ALUResult[0];
      2'b10:   w_misalign = |ALUResult[1:0];
      default: w_misalign = 1'b0;
    endcase

    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << ALUResult[1:0];
        w_wdata = {4{RD2[7:0]}};
      end
      2'b01: begin
        w_be    = ALUResult[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{RD2[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = RD2;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load lane select and extension, driven from the lane latched at launch
  // ---------------------------------------------------------------------------
  always_comb begin
    w_lane_byte = mem_rdata[{r_off, 3'b000} +: 8];
    w_lane_half = r_off[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_ld_size)
      2'b00:   w_load_ext = r_ld_unsigned ? {24'h0, w_lane_byte}
                                          : {{24{w_lane_byte[7]}}, w_lane_byte};
      2'b01:   w_load_ext = r_ld_unsigned ? {16'h0, w_lane_half}
                                          : {{16{w_lane_half[15]}}, w_lane_half};
      default: w_load_ext = mem_rdata;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and per-cycle control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next       = r_state;
    w_stall      = 1'b0;
    w_launch     = 1'b0;
    w_align_fail = 1'b0;
    w_take_ack   = 1'b0;
    w_timeout    = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_stall = w_access;
        if (w_access) begin
          if (!w_legal || w_misalign) begin
            w_align_fail = 1'b1;
            w_next       = S_DONE;
          end else begin
            w_launch = 1'b1;
            w_next   = S_REQ;
          end
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (mem_ack) begin
          w_take_ack = 1'b1;
          w_next     = S_DONE;
        end else if (r_cnt == CNT_LAST) begin
          w_timeout = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Bus, result and error registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK) begin
    if (!reset) begin
      r_mem_req     <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_wdata   <= '0;
      r_mem_be      <= '0;
      r_read_data   <= '0;
      r_align_err   <= 1'b0;
      r_bus_err     <= 1'b0;
      r_cnt         <= '0;
      r_ld_size     <= '0;
      r_ld_unsigned <= 1'b0;
      r_off         <= '0;
    end else begin
      if (w_launch) begin
        r_mem_req     <= 1'b1;
        r_mem_we      <= MemWrite;
        r_mem_addr    <= {ALUResult[31:2], 2'b00};
        r_mem_be      <= w_be;
        r_mem_wdata   <= w_wdata;
        r_ld_size     <= funct3[1:0];
        r_ld_unsigned <= funct3[2];
        r_off         <= ALUResult[1:0];
        r_cnt         <= '0;
      end

      if (w_align_fail) begin
        r_align_err <= 1'b1;
        r_read_data <= '0;
      end

      if (w_take_ack) begin
        r_mem_req   <= 1'b0;
        r_read_data <= r_mem_we ? 32'h0 : w_load_ext;
      end else if (w_timeout) begin
        r_mem_req   <= 1'b0;
        r_bus_err   <= 1'b1;
        r_read_data <= '0;
      end else if (r_state == S_REQ) begin
        r_cnt <= r_cnt + 8'd1;
      end

      // Errors are a one-cycle report; the core consumes them on the DONE edge.
      if (r_state == S_DONE) begin
        r_align_err <= 1'b0;
        r_bus_err   <= 1'b0;
      end
    end
  end

  assign Stall     = w_stall & reset;
  assign ReadData  = r_read_data;
  assign AlignErr  = r_align_err;
  assign BusErr    = r_bus_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_be    = r_mem_be;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed accesses from the datasheet examples plus random
// loads/stores, each checked against a byte-arithmetic model of the access rules.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        CLK = 1'b0;
  logic        reset = 1'b0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] ALUResult = '0;
  logic [31:0] RD2 = '0;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  logic [31:0] ReadData;
  logic        Stall;
  logic        AlignErr;
  logic        BusErr;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;

  int n_checks = 0;
  int n_errors = 0;

  load_store_unit #(.TIMEOUT(TO)) dut (
    .CLK       (CLK),
    .reset     (reset),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .funct3    (funct3),
    .ALUResult (ALUResult),
    .RD2       (RD2),
    .ReadData  (ReadData),
    .Stall     (Stall),
    .AlignErr  (AlignErr),
    .BusErr    (BusErr),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---- reference model: access size in bytes, legality, lanes, extension ----
  function automatic int size_bytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit is_legal(input logic [2:0] f3, input bit store);
    if (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) return 1'b1;
    if (f3 == 3'd4 || f3 == 3'd5) return !store;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_be(input int n, input logic [31:0] addr);
    int unsigned m;
    m = ((1 << n) - 1) << (addr % 4);
    return m[3:0];
  endfunction

  function automatic logic [31:0] model_wdata(input int n, input logic [31:0] rd2);
    if (n == 1) return {24'h0, rd2[7:0]} * 32'h0101_0101;
    if (n == 2) return {16'h0, rd2[15:0]} * 32'h0001_0001;
    return rd2;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    longint unsigned v;
    int n;
    n = size_bytes(f3);
    if (n == 4) return rdata;
    v = longint'(rdata >> (8 * (addr % 4))) % (64'd1 << (8 * n));
    if (!f3[2] && v >= (64'd1 << (8 * n - 1)))
      v = v + (64'd1 << 32) - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  // One complete access. ack_after = k acks in the k-th REQ cycle; 0 means never ack.
  task automatic access(input string tag, input bit st, input bit ld, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rd2,
                        input int ack_after, input logic [31:0] rdata);
    int          n;
    bit          err;
    bit          tmo;
    int          req_cycles;
    logic [31:0] exp_rd;
    n          = size_bytes(f3);
    err        = !is_legal(f3, st) || (addr % n != 0);
    tmo        = !(ack_after >= 1 && ack_after < TO);
    req_cycles = tmo ? TO : ack_after;
    exp_rd     = (err || tmo || st) ? 32'h0 : model_load(f3, addr, rdata);

    @(negedge CLK);
    MemWrite = st; MemRead = ld; funct3 = f3; ALUResult = addr; RD2 = rd2;
    #1 check({tag, ":stall_issue"}, Stall, 1);
    check({tag, ":req_idle"}, mem_req, 0);

    if (!err) begin
      for (int k = 1; k <= req_cycles; k++) begin
        @(negedge CLK);
        #1;
        check({tag, ":req"}, mem_req, 1);
        check({tag, ":stall_req"}, Stall, 1);
        check({tag, ":we"}, mem_we, st);
        check({tag, ":addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        if (st || n == 4) check({tag, ":be"}, mem_be, model_be(n, addr));
        if (st) check({tag, ":wdata"}, mem_wdata, model_wdata(n, rd2));
        mem_ack   = (k == ack_after);
        mem_rdata = (k == ack_after) ? rdata : $urandom;
      end
    end

    @(negedge CLK);
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    #1;
    check({tag, ":stall_done"}, Stall, 0);
    check({tag, ":req_done"}, mem_req, 0);
    check({tag, ":align_err"}, AlignErr, err);
    check({tag, ":bus_err"}, BusErr, !err && tmo);
    check({tag, ":read_data"}, ReadData, exp_rd);

    @(negedge CLK);
    mem_ack = 1'b0;
    #1;
    check({tag, ":stall_idle"}, Stall, 0);
    check({tag, ":align_clr"}, AlignErr, 0);
    check({tag, ":bus_clr"}, BusErr, 0);
    check({tag, ":req_idle2"}, mem_req, 0);
  endtask

  initial begin
    // Reset: outputs cleared and Stall held low even with a load presented
    MemRead = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    check("rst:stall", Stall, 0);
    check("rst:req", mem_req, 0);
    check("rst:we", mem_we, 0);
    check("rst:be", mem_be, 0);
    check("rst:addr", mem_addr, 0);
    check("rst:wdata", mem_wdata, 0);
    check("rst:rdata", ReadData, 0);
    check("rst:align", AlignErr, 0);
    check("rst:bus", BusErr, 0);
    MemRead = 1'b0;
    @(negedge CLK);
    reset = 1'b1;

    // Datasheet examples
    access("lw",       0, 1, 3'b010, 32'h0000_0100, 32'h0,          2, 32'hDEAD_BEEF);
    access("lb",       0, 1, 3'b000, 32'h0000_0103, 32'h0,          1, 32'h8012_3456);
    access("lbu",      0, 1, 3'b100, 32'h0000_0103, 32'h0,          1, 32'h8012_3456);
    access("lhu",      0, 1, 3'b101, 32'h0000_0102, 32'h0,          3, 32'h8012_3456);
    access("sh",       1, 0, 3'b001, 32'h0000_0202, 32'h1234_ABCD,  1, 32'h0);
    access("lw_mis",   0, 1, 3'b010, 32'h0000_0101, 32'h0,          1, 32'h0);
    access("f3_011",   0, 1, 3'b011, 32'h0000_0100, 32'h0,          1, 32'h0);
    access("timeout",  0, 1, 3'b010, 32'h0000_0300, 32'h0,          0, 32'h0);

    // Boundaries: every SB lane, LH sign, store with a load-only funct3, store priority
    for (int i = 0; i < 4; i++)
      access("sb_lane", 1, 0, 3'b000, 32'h0000_0400 + i, 32'hCAFE_F00D, 1, 32'h0);
    access("lh_neg",   0, 1, 3'b001, 32'h0000_0500, 32'h0,          2, 32'h1234_9ABC);
    access("sh_mis",   1, 0, 3'b001, 32'h0000_0201, 32'h1111_2222,  1, 32'h0);
    access("sbu_ill",  1, 0, 3'b100, 32'h0000_0200, 32'h1111_2222,  1, 32'h0);
    access("st_prio",  1, 1, 3'b010, 32'h0000_0600, 32'h5555_AAAA,  TO - 1, 32'h0);
    access("st_tmo",   1, 0, 3'b010, 32'h0000_0700, 32'h0F0F_0F0F,  0, 32'h0);

    // Reset while REQ is outstanding abandons the access silently
    @(negedge CLK);
    MemRead = 1'b1; funct3 = 3'b010; ALUResult = 32'h0000_0800;
    @(negedge CLK);
    #1 check("rstreq:req_on", mem_req, 1);
    reset = 1'b0;
    @(negedge CLK);
    #1;
    check("rstreq:req", mem_req, 0);
    check("rstreq:stall", Stall, 0);
    MemRead = 1'b0;
    reset   = 1'b1;
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    @(negedge CLK);
    mem_ack = 1'b0;
    #1;
    check("rstreq:req2", mem_req, 0);
    check("rstreq:stall2", Stall, 0);
    check("rstreq:align", AlignErr, 0);
    check("rstreq:bus", BusErr, 0);
    check("rstreq:rdata", ReadData, 0);
    @(negedge CLK);
    #1 check("rstreq:bus2", BusErr, 0);

    // Randomized accesses
    for (int i = 0; i < 40; i++) begin
      bit          st;
      bit          ld;
      logic [2:0]  f3;
      logic [31:0] addr;
      st   = 1'($urandom_range(0, 1));
      ld   = st ? 1'($urandom_range(0, 1)) : 1'b1;
      f3   = 3'($urandom_range(0, 7));
      addr = $urandom;
      access("rand", st, ld, f3, addr, $urandom, $urandom_range(0, TO - 1), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
